// File: rtl/xgs_spi_master.sv
// XGS sensor SPI control master.
// One 32-bit frame per command: {addr[14:0], rnw, data[15:0]}, MSB first.
module xgs_spi_master #(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 10
) (
    input  logic        sys_clk,
    input  logic        sys_reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rnw,
    input  logic [14:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        busy,
    output logic        spi_sclk,
    output logic        spi_cs_n,
    output logic        spi_sdout,
    input  logic        spi_sdin
);

    typedef enum logic [2:0] {IDLE, LEAD, LOW, HIGH, TRAIL, GAP} state_t;

    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_M1 = 8'(CS_GAP - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [4:0]  bit_q;
    logic [31:0] sr_q;
    logic [31:0] sr_d;
    logic [15:0] rd_q;
    logic [15:0] rd_d;
    logic        rnw_q;
    logic        cs_n_q;
    logic        sclk_q;
    logic        sdout_q;
    logic        ready_q;
    logic        busy_q;
    logic        rsp_valid_q;
    logic [15:0] rsp_rdata_q;
    logic        tc;

    assign tc   = (cnt_q == 8'd0);
    assign sr_d = {sr_q[30:0], 1'b0};
    assign rd_d = {rd_q[14:0], spi_sdin};

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign spi_sclk  = sclk_q;
    assign spi_cs_n  = cs_n_q;
    assign spi_sdout = sdout_q;

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            sr_q        <= '0;
            rd_q        <= '0;
            rnw_q       <= 1'b0;
            cs_n_q      <= 1'b1;
            sclk_q      <= 1'b0;
            sdout_q     <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            // Every timed state counts down; transitions reload below.
            if (state_q != IDLE) cnt_q <= cnt_q - 8'd1;
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        sr_q    <= {cmd_addr, cmd_rnw,
                                    cmd_rnw ? 16'h0000 : cmd_wdata};
                        rnw_q   <= cmd_rnw;
                        rd_q    <= '0;
                        bit_q   <= '0;
                        cnt_q   <= DIV_M1;
                        cs_n_q  <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= LEAD;
                    end
                end
                LEAD: begin
                    if (tc) begin
                        sdout_q <= sr_q[31];
                        cnt_q   <= DIV_M1;
                        state_q <= LOW;
                    end
                end
                LOW: begin
                    if (tc) begin
                        // Sample on the same edge SCLK rises.
                        if (rnw_q && bit_q[4]) rd_q <= rd_d;
                        sclk_q  <= 1'b1;
                        cnt_q   <= DIV_M1;
                        state_q <= HIGH;
                    end
                end
                HIGH: begin
                    if (tc) begin
                        sclk_q <= 1'b0;
                        sr_q   <= sr_d;
                        bit_q  <= bit_q + 5'd1;
                        cnt_q  <= DIV_M1;
                        if (bit_q == 5'd31) begin
                            sdout_q <= 1'b0;
                            state_q <= TRAIL;
                        end else begin
                            sdout_q <= sr_d[31];
                            state_q <= LOW;
                        end
                    end
                end
                TRAIL: begin
                    if (tc) begin
                        cs_n_q      <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rnw_q ? rd_q : 16'h0000;
                        cnt_q       <= GAP_M1;
                        state_q     <= GAP;
                    end
                end
                GAP: begin
                    if (tc) begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xgs_spi_master.sv
// Bench for xgs_spi_master: two instances (CLK_DIV=2/CS_GAP=10 and 1/1)
// with an SPI sensor model and frame monitor.
module tb_xgs_spi_master;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  cv    = '0;
    logic [1:0]  rnw   = '0;
    logic [1:0]  sdi   = '0;
    logic [1:0]  cr, rv, bsy, sclk, csn, sdo;
    logic [14:0] addr[2];
    logic [15:0] wd[2];
    logic [15:0] rd[2];
    logic [15:0] sens[2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int hs[2], prev_hs[2], hs_n[2], fall[2], fall_n[2], rise[2], gap[2];
    int cslen[2], last_len[2], np[2], last_np[2], first[2], lastr[2];
    int minp[2], maxp[2], rsp_n[2], stab_viol[2], rdy_viol[2];
    logic [31:0] cap[2], last_frm[2], prev_frm[2];
    logic [15:0] rsp_last[2];
    logic [1:0]  p_cs = 2'b11;
    logic [1:0]  p_sc = 2'b00;
    logic [1:0]  p_sdo = 2'b00;

    xgs_spi_master #(.CLK_DIV(2), .CS_GAP(10)) u_dut0 (
        .sys_clk(clk), .sys_reset_n(rst_n),
        .cmd_valid(cv[0]), .cmd_ready(cr[0]), .cmd_rnw(rnw[0]),
        .cmd_addr(addr[0]), .cmd_wdata(wd[0]),
        .rsp_valid(rv[0]), .rsp_rdata(rd[0]), .busy(bsy[0]),
        .spi_sclk(sclk[0]), .spi_cs_n(csn[0]),
        .spi_sdout(sdo[0]), .spi_sdin(sdi[0])
    );

    xgs_spi_master #(.CLK_DIV(1), .CS_GAP(1)) u_dut1 (
        .sys_clk(clk), .sys_reset_n(rst_n),
        .cmd_valid(cv[1]), .cmd_ready(cr[1]), .cmd_rnw(rnw[1]),
        .cmd_addr(addr[1]), .cmd_wdata(wd[1]),
        .rsp_valid(rv[1]), .rsp_rdata(rd[1]), .busy(bsy[1]),
        .spi_sclk(sclk[1]), .spi_cs_n(csn[1]),
        .spi_sdout(sdo[1]), .spi_sdin(sdi[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dv(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic int cg(input int k);
        return (k == 0) ? 10 : 1;
    endfunction

    // Pin monitor and sensor model, sampled mid-cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (cv[k] && cr[k]) begin
                prev_hs[k] = hs[k];
                hs[k] = cyc;
                hs_n[k]++;
            end
            if (!csn[k] && p_cs[k]) begin
                gap[k] = cyc - rise[k];
                fall[k] = cyc;
                fall_n[k]++;
                cslen[k] = 0;
                np[k] = 0;
                minp[k] = 1 << 20;
                maxp[k] = 0;
            end
            if (!csn[k]) cslen[k]++;
            if (csn[k] && !p_cs[k]) begin
                rise[k] = cyc;
                last_len[k] = cslen[k];
                prev_frm[k] = last_frm[k];
                last_frm[k] = cap[k];
                last_np[k] = np[k];
            end
            if (sclk[k] && !p_sc[k]) begin
                cap[k] = {cap[k][30:0], sdo[k]};
                if (np[k] == 0) first[k] = cyc;
                else begin
                    if (cyc - lastr[k] < minp[k]) minp[k] = cyc - lastr[k];
                    if (cyc - lastr[k] > maxp[k]) maxp[k] = cyc - lastr[k];
                end
                lastr[k] = cyc;
                np[k]++;
            end
            if (!sclk[k] && p_sc[k])
                sdi[k] = (np[k] >= 16 && np[k] < 32) ?
                         sens[k][4'(31 - np[k])] : 1'b0;
            if (sclk[k] && sdo[k] != p_sdo[k]) stab_viol[k]++;
            if (cr[k] == bsy[k]) rdy_viol[k]++;
            if (rv[k]) begin
                rsp_n[k]++;
                rsp_last[k] = rd[k];
            end
            p_cs[k] = csn[k];
            p_sc[k] = sclk[k];
            p_sdo[k] = sdo[k];
        end
    end

    task automatic wait_ready(input int k);
        int t = 0;
        while (!cr[k] && t < 3000) begin
            @(posedge clk); #1; t++;
        end
    endtask

    // One command through instance k, checked against the frame rules.
    task automatic xfer(input int k, input logic r, input logic [14:0] a,
                        input logic [15:0] w, input logic [15:0] s);
        int n0, t;
        logic [31:0] ef;
        logic [15:0] er;
        ef = {a, r, r ? 16'h0000 : w};
        er = r ? s : 16'h0000;
        sens[k] = s;
        wait_ready(k);
        n0 = rsp_n[k];
        rnw[k] = r; addr[k] = a; wd[k] = w; cv[k] = 1'b1;
        @(posedge clk); #1;
        cv[k] = 1'b0;
        t = 0;
        while (rsp_n[k] == n0 && t < 3000) begin
            @(posedge clk); #1; t++;
        end
        wait_ready(k);
        checks++;
        if (rsp_n[k] !== n0 + 1) begin
            errors++;
            $display("FAIL rsp_count i%0d: got %0d want %0d",
                     k, rsp_n[k] - n0, 1);
        end
        checks++;
        if (last_frm[k] !== ef) begin
            errors++;
            $display("FAIL frame i%0d: got %h want %h", k, last_frm[k], ef);
        end
        checks++;
        if (last_np[k] !== 32) begin
            errors++;
            $display("FAIL pulses i%0d: got %0d want 32", k, last_np[k]);
        end
        checks++;
        if (last_len[k] !== 66 * dv(k)) begin
            errors++;
            $display("FAIL cs_len i%0d: got %0d want %0d",
                     k, last_len[k], 66 * dv(k));
        end
        checks++;
        if (fall[k] - hs[k] !== 1 || first[k] - hs[k] !== 1 + 2 * dv(k)) begin
            errors++;
            $display("FAIL lead i%0d: cs %0d sclk %0d want 1 %0d", k,
                     fall[k] - hs[k], first[k] - hs[k], 1 + 2 * dv(k));
        end
        checks++;
        if (minp[k] !== 2 * dv(k) || maxp[k] !== 2 * dv(k)) begin
            errors++;
            $display("FAIL sclk_period i%0d: got %0d..%0d want %0d",
                     k, minp[k], maxp[k], 2 * dv(k));
        end
        checks++;
        if (rsp_last[k] !== er || rd[k] !== er) begin
            errors++;
            $display("FAIL rdata i%0d: got %h/%h want %h",
                     k, rsp_last[k], rd[k], er);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({csn[k], sclk[k], sdo[k], cr[k], rv[k], bsy[k]} !== 6'b100100) begin
                errors++;
                $display("FAIL reset_pins i%0d: got %b want 100100", k,
                         {csn[k], sclk[k], sdo[k], cr[k], rv[k], bsy[k]});
            end
            checks++;
            if (rd[k] !== 16'h0000) begin
                errors++;
                $display("FAIL reset_rdata i%0d: got %h want 0000", k, rd[k]);
            end
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_write;
        xfer(0, 1'b0, 15'h3700, 16'h001C, 16'hFFFF);
    endtask

    task automatic test_read;
        xfer(0, 1'b1, 15'h3000, 16'hABCD, 16'h0058);
    endtask

    task automatic test_back_to_back;
        int n0, h0, t;
        sens[0] = 16'h0000;
        wait_ready(0);
        n0 = rsp_n[0];
        h0 = hs_n[0];
        rnw[0] = 1'b0; addr[0] = 15'h3E3E; wd[0] = 16'h0001; cv[0] = 1'b1;
        @(posedge clk); #1;
        addr[0] = 15'h3E28; wd[0] = 16'h2537;
        t = 0;
        while (hs_n[0] < h0 + 2 && t < 3000) begin
            @(posedge clk); #1; t++;
        end
        cv[0] = 1'b0;
        t = 0;
        while (rsp_n[0] < n0 + 2 && t < 3000) begin
            @(posedge clk); #1; t++;
        end
        checks++;
        if (hs_n[0] !== h0 + 2 || rsp_n[0] !== n0 + 2) begin
            errors++;
            $display("FAIL b2b_count: hs %0d rsp %0d want 2 2",
                     hs_n[0] - h0, rsp_n[0] - n0);
        end
        checks++;
        if (prev_frm[0] !== {15'h3E3E, 1'b0, 16'h0001} ||
            last_frm[0] !== {15'h3E28, 1'b0, 16'h2537}) begin
            errors++;
            $display("FAIL b2b_frames: got %h %h want %h %h",
                     prev_frm[0], last_frm[0],
                     {15'h3E3E, 1'b0, 16'h0001}, {15'h3E28, 1'b0, 16'h2537});
        end
        checks++;
        if (gap[0] !== cg(0) + 1) begin
            errors++;
            $display("FAIL b2b_gap: got %0d want %0d", gap[0], cg(0) + 1);
        end
        checks++;
        if (hs[0] - prev_hs[0] !== 1 + 66 * dv(0) + cg(0)) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d want %0d",
                     hs[0] - prev_hs[0], 1 + 66 * dv(0) + cg(0));
        end
    endtask

    task automatic test_reset_mid;
        int n0, f0, t;
        sens[0] = 16'hC3A5;
        wait_ready(0);
        n0 = rsp_n[0];
        rnw[0] = 1'b1; addr[0] = 15'h1234; wd[0] = 16'h0; cv[0] = 1'b1;
        @(posedge clk); #1;
        cv[0] = 1'b0;
        t = 0;
        while (np[0] < 20 && t < 3000) begin
            @(posedge clk); #1; t++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({csn[0], sclk[0], sdo[0], rv[0], bsy[0], cr[0]} !== 6'b100001) begin
            errors++;
            $display("FAIL midreset_pins: got %b want 100001 after %0d pulses",
                     {csn[0], sclk[0], sdo[0], rv[0], bsy[0], cr[0]}, np[0]);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        f0 = fall_n[0];
        repeat (200) @(posedge clk);
        #1;
        checks++;
        if (rsp_n[0] !== n0 || fall_n[0] !== f0) begin
            errors++;
            $display("FAIL midreset_quiet: rsp %0d cs_falls %0d want 0 0",
                     rsp_n[0] - n0, fall_n[0] - f0);
        end
        xfer(0, 1'b1, 15'h31FE, 16'h0000, 16'h5AF0);
    endtask

    task automatic test_fast;
        xfer(1, 1'b1, 15'h3000, 16'h0000, 16'h0058);
        xfer(1, 1'b0, 15'h3E28, 16'h2537, 16'h1111);
    endtask

    task automatic test_read_then_write;
        logic [15:0] s;
        int n0, t, bad;
        s = 16'($urandom) | 16'h0001;
        xfer(0, 1'b1, 15'h2A55, 16'h0000, s);
        wait_ready(0);
        n0 = rsp_n[0];
        rnw[0] = 1'b0; addr[0] = 15'h0F0F; wd[0] = 16'hBEEF; cv[0] = 1'b1;
        @(posedge clk); #1;
        cv[0] = 1'b0;
        t = 0;
        bad = 0;
        while (rsp_n[0] == n0 && t < 3000) begin
            if (!rv[0] && rd[0] !== s) bad++;
            @(posedge clk); #1; t++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL rdata_hold: %0d cycles differed from %h", bad, s);
        end
        checks++;
        if (rd[0] !== 16'h0000 || rsp_n[0] !== n0 + 1) begin
            errors++;
            $display("FAIL rdata_after_write: got %h want 0000", rd[0]);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 16; i++) begin
            xfer(int'($urandom_range(0, 1)), 1'($urandom),
                 15'($urandom), 16'($urandom), 16'($urandom));
        end
    endtask

    task automatic test_invariants;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (stab_viol[k] !== 0) begin
                errors++;
                $display("FAIL sdout_stable i%0d: got %0d changes want 0",
                         k, stab_viol[k]);
            end
            checks++;
            if (rdy_viol[k] !== 0) begin
                errors++;
                $display("FAIL ready_vs_busy i%0d: got %0d cycles want 0",
                         k, rdy_viol[k]);
            end
        end
    endtask

    initial begin
        addr[0] = '0; addr[1] = '0;
        wd[0] = '0; wd[1] = '0;
        sens[0] = '0; sens[1] = '0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid();
        test_fast();
        test_read_then_write();
        test_random();
        test_invariants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xgs_spi_master.md
# xgs_spi_master

Serial control master for the XGS image sensor. Converts single register commands (15-bit address, 16-bit data, read/write flag) from the host register file into the sensor's 32-bit SPI frame, and returns read data. Sits between the AXI-lite register bank and the sensor pins; the same frame format is what the XGS sensor model accepts on its SCLK/CS/SDATA/SDATAOUT pins.

## Interface
Parameters:
- CLK_DIV, 2: sys_clk cycles per SCLK half-period; legal range 1..255.
- CS_GAP, 10: sys_clk cycles CS stays high after a frame before the next frame may start; legal range 1..255.

Ports:
- sys_clk  in  1  block clock; all logic on its rising edge.
- sys_reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted on a cycle where cmd_valid and cmd_ready are both high.
- cmd_rnw  in  1  1 = read, 0 = write.
- cmd_addr  in  15  sensor register address.
- cmd_wdata  in  16  write data; ignored for reads.
- rsp_valid  out  1  one-cycle pulse at frame completion.
- rsp_rdata  out  16  read data; held until the next rsp_valid; 0x0000 after writes.
- busy  out  1  high from command acceptance through the end of GAP.
- spi_sclk  out  1  serial clock, idles low.
- spi_cs_n  out  1  chip select, active low.
- spi_sdout  out  1  master-to-sensor data.
- spi_sdin  in  1  sensor-to-master data; synchronous to spi_sclk.

## Operation
- Frame: 15 address bits (MSB first), 1 R/W tag bit (1 = read), then 16 data bits (MSB first). Total 32 SCLK pulses.
- States: IDLE, LEAD, LOW, HIGH, TRAIL, GAP.
- IDLE: cmd_ready=1. On handshake, latch addr/rnw/wdata into a 32-bit shift register {addr, rnw, wdata or 0}, clear bit counter, go to LEAD.
- LEAD: CS low, SCLK low, sdout = 0, CLK_DIV cycles; then LOW.
- LOW: SCLK low, sdout = current MSB of shift register, CLK_DIV cycles; then HIGH.
- HIGH: SCLK high, CLK_DIV cycles. On entry (the cycle SCLK rises) sdin is sampled into the read shift register when bit counter ≥ 16 and rnw = 1. On exit, shift, increment counter; counter = 31 → TRAIL, else LOW.
- TRAIL: CS low, SCLK low, sdout 0, CLK_DIV cycles; on exit CS goes high, rsp_valid pulses, rsp_rdata updates, go to GAP.
- GAP: CS high, CS_GAP cycles; then IDLE.
- Half-period counter is 8 bits, reloads on every state change; bit counter 5 bits.
- cmd_valid while busy: not accepted; held inputs are taken on first IDLE cycle.
- sdout during read data phase is 0.

## Timing
- Reset values: spi_cs_n=1, spi_sclk=0, spi_sdout=0, cmd_ready=1 (in IDLE), rsp_valid=0, rsp_rdata=0x0000, busy=0; state IDLE.
- All SPI outputs registered; no combinational path from cmd_* to spi_*.
- CS falls the cycle after handshake. First SCLK rise at handshake + 1 + 2·CLK_DIV cycles.
- CS low duration = (2 + 64)·CLK_DIV... precisely LEAD + 32·(LOW+HIGH) + TRAIL = 66·CLK_DIV cycles.
- rsp_valid asserts the cycle CS rises. Command-to-command minimum spacing = 1 + 66·CLK_DIV + CS_GAP cycles.
- sdout stable for full HIGH half-period and changes only when SCLK is low.
- Asynchronous reset mid-frame: all outputs return immediately to reset values; no rsp_valid for the aborted frame; a fresh frame starts only after a new handshake.

## Test plan
- Write 0x3700 ← 0x001C, CLK_DIV=2: capture 32 bits on SCLK rises = 0x3700<<17 | 0<<16 | 0x001C; CS low exactly 132 cycles; rsp_valid once, rsp_rdata=0x0000.
- Read 0x3000 with sensor model returning 0x0058: tag bit = 1, sdout 0 during data phase, rsp_rdata=0x0058 on rsp_valid.
- Back-to-back: cmd_valid held high for write 0x3E3E←0x0001 then write 0x3E28←0x2537: second CS fall exactly CS_GAP+1 cycles after first CS rise; both frames bit-exact; cmd_ready low throughout busy.
- Reset asserted at SCLK pulse 20 of a read: CS high, SCLK low, sdout 0 immediately; no rsp_valid; subsequent read 0x31FE completes correctly.
- CLK_DIV=1, CS_GAP=1: read 0x3000 returns 0x0058; frame length 66 cycles; SCLK period 2 cycles.
- Read followed by write: rsp_rdata holds read value until write's rsp_valid, then 0x0000.
